// File: rtl/risc_instr_fetch.sv
// rtl/risc_instr_fetch.sv - IF stage: fetch PC, imem req/ack handshake, IF/DOF register, redirect squash
module risc_instr_fetch #(
  parameter logic [7:0]  START_PC = 8'h00,
  parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
  input  logic        CLK,
  input  logic        reset,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [7:0]  redirect_pc,
  output logic        imem_req,
  output logic [7:0]  imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_data,
  output logic [7:0]  PC_1,
  output logic [31:0] IR,
  output logic        branch_predict
);

  typedef enum logic [1:0] {RST, FETCH, HOLD, DRAIN} state_t;

  state_t      state_q;
  logic [7:0]  pc_q;
  logic [7:0]  pc1_q;
  logic [31:0] ir_q;
  logic        bp_q;
  logic [31:0] buf_q;
  logic [7:0]  buf_addr_q;
  logic [7:0]  out_addr_q;

  always_ff @(negedge CLK or posedge reset) begin
    if (reset) begin
      state_q    <= RST;
      pc_q       <= START_PC;
      pc1_q      <= 8'h00;
      ir_q       <= NOP_WORD;
      bp_q       <= 1'b0;
      buf_q      <= 32'h0;
      buf_addr_q <= 8'h00;
      out_addr_q <= START_PC;
    end else begin
      case (state_q)
        RST: state_q <= FETCH;
        FETCH: begin
          if (redirect_valid) begin
            pc_q <= redirect_pc;
            ir_q <= NOP_WORD;
            bp_q <= 1'b0;
            // Unacked request must finish on its old address before refetching
            if (!imem_ack) begin
              out_addr_q <= pc_q;
              state_q    <= DRAIN;
            end
          end else if (imem_ack && stall) begin
            buf_q      <= imem_data;
            buf_addr_q <= pc_q;
            state_q    <= HOLD;
          end else if (imem_ack) begin
            ir_q  <= imem_data;
            pc1_q <= pc_q + 8'd1;
            bp_q  <= 1'b1;
            pc_q  <= pc_q + 8'd1;
          end else if (!stall) begin
            ir_q <= NOP_WORD;
            bp_q <= 1'b0;
          end
        end
        HOLD: begin
          if (redirect_valid) begin
            pc_q    <= redirect_pc;
            ir_q    <= NOP_WORD;
            bp_q    <= 1'b0;
            state_q <= FETCH;
          end else if (!stall) begin
            ir_q    <= buf_q;
            pc1_q   <= buf_addr_q + 8'd1;
            bp_q    <= 1'b1;
            pc_q    <= pc_q + 8'd1;
            state_q <= FETCH;
          end
        end
        DRAIN: begin
          if (redirect_valid) pc_q <= redirect_pc;
          if (imem_ack) state_q <= FETCH;
        end
        default: state_q <= RST;
      endcase
    end
  end

  assign imem_req       = (state_q == FETCH) || (state_q == DRAIN);
  assign imem_addr      = (state_q == DRAIN) ? out_addr_q : pc_q;
  assign PC_1           = pc1_q;
  assign IR             = ir_q;
  assign branch_predict = bp_q;

endmodule

// File: tb/tb_risc_instr_fetch.sv
// tb/tb_risc_instr_fetch.sv - scoreboard bench for risc_instr_fetch
module tb_risc_instr_fetch;

  logic        CLK = 1'b0;
  logic        reset;
  logic        stall;
  logic        redirect_valid;
  logic [7:0]  redirect_pc;
  logic        imem_req;
  logic [7:0]  imem_addr;
  logic        imem_ack;
  logic [31:0] imem_data;
  logic [7:0]  PC_1;
  logic [31:0] IR;
  logic        branch_predict;

  int          n_checks = 0;
  int          n_fail = 0;
  logic [39:0] exp_q[$];
  logic [39:0] mon_e;
  logic        stall_at_edge = 1'b0;

  always #5 CLK = ~CLK;

  function automatic logic [31:0] mem_word(input logic [7:0] a);
    if (a == 8'h05) return 32'hDEADBEEF;
    return {8'hC0, a, ~a, a ^ 8'h5A};
  endfunction

  assign imem_data = mem_word(imem_addr);

  risc_instr_fetch dut (
    .CLK(CLK), .reset(reset), .stall(stall),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_data(imem_data),
    .PC_1(PC_1), .IR(IR), .branch_predict(branch_predict)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge CLK) stall_at_edge <= stall;

  // A valid IR after an edge with stall low is a newly delivered instruction
  always @(posedge CLK) begin
    if (!reset && branch_predict && !stall_at_edge) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_instr: got PC_1 %h IR %h expected none", PC_1, IR);
      end else begin
        mon_e = exp_q.pop_front();
        check("PC_1", {24'h0, PC_1}, {24'h0, mon_e[39:32]});
        check("IR", IR, mon_e[31:0]);
      end
    end
  end

  task automatic cyc(input logic ack, input logic st, input logic rv, input logic [7:0] rpc);
    @(posedge CLK);
    #1;
    imem_ack = ack;
    stall = st;
    redirect_valid = rv;
    redirect_pc = rpc;
  endtask

  task automatic hs(input logic req, input logic [7:0] addr, input logic bp);
    check("imem_req", {31'h0, imem_req}, {31'h0, req});
    if (req) check("imem_addr", {24'h0, imem_addr}, {24'h0, addr});
    check("branch_predict", {31'h0, branch_predict}, {31'h0, bp});
  endtask

  task automatic push(input logic [7:0] pc1, input logic [31:0] word);
    exp_q.push_back({pc1, word});
  endtask

  task automatic reset_checks();
    check("rst_IR", IR, 32'h0);
    check("rst_PC_1", {24'h0, PC_1}, 32'h0);
    check("rst_bp", {31'h0, branch_predict}, 32'h0);
    check("rst_req", {31'h0, imem_req}, 32'h0);
    check("rst_addr", {24'h0, imem_addr}, 32'h0);
  endtask

  task automatic mid_reset();
    @(posedge CLK);
    #2;
    reset = 1'b1;
    imem_ack = 1'b1;
    stall = 1'b0;
    redirect_valid = 1'b0;
    #1;
    reset_checks();
    @(posedge CLK);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b1;
    stall = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc = 8'h00;
    imem_ack = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    reset_checks();
    reset = 1'b0;
    imem_ack = 1'b1;

    // zero-wait memory
    cyc(1, 0, 0, 8'h00); hs(1, 8'h00, 0); push(8'h01, mem_word(8'h00));
    cyc(1, 0, 0, 8'h00); hs(1, 8'h01, 1); push(8'h02, mem_word(8'h01));
    cyc(1, 0, 0, 8'h00); hs(1, 8'h02, 1); push(8'h03, mem_word(8'h02));
    cyc(1, 0, 0, 8'h00); hs(1, 8'h03, 1); push(8'h04, mem_word(8'h03));

    // ack every third cycle
    cyc(0, 0, 0, 8'h00); hs(1, 8'h04, 1);
    cyc(0, 0, 0, 8'h00); hs(1, 8'h04, 0);
    cyc(1, 0, 0, 8'h00); hs(1, 8'h04, 0); push(8'h05, 32'hC004FB5E);

    // stall coincident with ack of DEADBEEF at 05
    cyc(1, 1, 0, 8'h00); hs(1, 8'h05, 1);
    cyc(0, 1, 0, 8'h00); hs(0, 8'h00, 1);
    check("IR_frozen", IR, 32'hC004FB5E);
    check("PC_1_frozen", {24'h0, PC_1}, 32'h05);
    cyc(0, 1, 0, 8'h00); hs(0, 8'h00, 1);
    cyc(0, 0, 0, 8'h00); hs(0, 8'h00, 1); push(8'h06, 32'hDEADBEEF);
    cyc(1, 0, 0, 8'h00); hs(1, 8'h06, 1); push(8'h07, mem_word(8'h06));

    // redirect with request outstanding, then drain
    cyc(0, 0, 1, 8'h40); hs(1, 8'h07, 1);
    cyc(0, 1, 0, 8'h00); hs(1, 8'h07, 0);
    check("IR_nop", IR, 32'h0);
    cyc(1, 0, 0, 8'h00); hs(1, 8'h07, 0);
    cyc(1, 0, 0, 8'h00); hs(1, 8'h40, 0); push(8'h41, mem_word(8'h40));

    // redirect with ack and stall, then redirect overwrite during drain, then wrap
    cyc(1, 1, 1, 8'hFE); hs(1, 8'h41, 1);
    cyc(0, 0, 1, 8'h20); hs(1, 8'hFE, 0);
    cyc(0, 0, 1, 8'hFF); hs(1, 8'hFE, 0);
    cyc(1, 0, 0, 8'h00); hs(1, 8'hFE, 0);
    cyc(1, 0, 0, 8'h00); hs(1, 8'hFF, 0); push(8'h00, mem_word(8'hFF));
    cyc(1, 0, 0, 8'h00); hs(1, 8'h00, 1); push(8'h01, mem_word(8'h00));

    // redirect beats stall in HOLD
    cyc(1, 1, 0, 8'h00); hs(1, 8'h01, 1);
    cyc(0, 1, 1, 8'h30); hs(0, 8'h00, 1);
    cyc(1, 0, 0, 8'h00); hs(1, 8'h30, 0); push(8'h31, mem_word(8'h30));

    // reset mid-HOLD
    cyc(1, 1, 0, 8'h00); hs(1, 8'h31, 1);
    mid_reset();
    cyc(1, 0, 0, 8'h00); hs(1, 8'h00, 0); push(8'h01, mem_word(8'h00));

    // reset mid-DRAIN
    cyc(0, 0, 1, 8'h50); hs(1, 8'h01, 1);
    cyc(0, 0, 0, 8'h00); hs(1, 8'h01, 0);
    mid_reset();
    cyc(1, 0, 0, 8'h00); hs(1, 8'h00, 0); push(8'h01, mem_word(8'h00));
    cyc(0, 0, 0, 8'h00); hs(1, 8'h01, 1);
    cyc(0, 0, 0, 8'h00); hs(1, 8'h01, 0);

    repeat (2) @(posedge CLK);
    #1;
    check("queue_empty", exp_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/risc_instr_fetch.md
Name: risc_instr_fetch

Overview:
- Instruction-fetch (IF) stage of the 32-bit RISC pipeline; sits directly upstream of the decode/operand-fetch stage and drives its PC_1, IR and branch_predict inputs.
- Generates the 8-bit fetch PC and runs a req/ack handshake with a variable-latency instruction memory.
- Holds its IF/DOF register on a pipeline stall.
- Redirects the PC on a taken branch/jump resolved downstream, squashing wrong-path words by driving branch_predict low (bubble).

Parameters:
- START_PC, 8'h00, PC loaded on reset.
- NOP_WORD, 32'h00000000, IR value driven for bubbles and during reset.

Ports:
- CLK  input  1  clock; all registers update on the falling edge.
- reset  input  1  asynchronous, active-high reset.
- stall  input  1  hold the IF/DOF register and the PC (load-use hazard from downstream).
- redirect_valid  input  1  taken branch/jump resolved downstream this cycle.
- redirect_pc  input  8  branch/jump target.
- imem_req  output  1  fetch request to instruction memory.
- imem_addr  output  8  fetch address.
- imem_ack  input  1  imem_data is valid for the current request.
- imem_data  input  32  instruction word.
- PC_1  output  8  fetched address + 1, mod 256.
- IR  output  32  fetched instruction.
- branch_predict  output  1  1 = IR is valid; 0 = bubble/squashed.

Behaviour:
- Reset (asynchronous, any state, mid-handshake included):
  - PC = START_PC, PC_1 = 0, IR = NOP_WORD, branch_predict = 0, hold buffer cleared, state = RST.
  - Any ack that arrives during reset is ignored.
- Internal state:
  - PC, the next address to fetch.
  - 32-bit hold buffer plus its address.
  - FSM with states RST, FETCH, HOLD, DRAIN.
- Handshake rules:
  - imem_req = 1 in FETCH and DRAIN, 0 in RST and HOLD.
  - imem_addr = PC in FETCH; it is the latched outstanding address in DRAIN.
  - imem_addr is stable while imem_req = 1 and imem_ack = 0.
  - An ack with imem_req = 0 is ignored.
- RST: on the first falling edge after reset deasserts, go to FETCH. Outputs unchanged.
- FETCH, evaluated per falling edge in priority order:
  1. redirect_valid, with ack: discard the word. PC <= redirect_pc, IR <= NOP_WORD, branch_predict <= 0. Stay in FETCH.
  2. redirect_valid, no ack: go to DRAIN. PC <= redirect_pc, IR <= NOP_WORD, branch_predict <= 0. Request stays on the old address.
  3. ack and stall: buffer <= imem_data and its address. IF/DOF register holds. Go to HOLD.
  4. ack, no stall: IR <= imem_data, PC_1 <= PC+1, branch_predict <= 1, PC <= PC+1 (8'hFF wraps to 8'h00).
  5. no ack, stall: everything holds.
  6. no ack, no stall: IR <= NOP_WORD, branch_predict <= 0. PC holds.
- HOLD:
  - redirect_valid: discard the buffer. PC <= redirect_pc, IR <= NOP_WORD, branch_predict <= 0. Go to FETCH. Redirect beats stall.
  - stall: hold.
  - Otherwise: IR <= buffer, PC_1 <= buffer address + 1, branch_predict <= 1, PC <= PC+1. Go to FETCH.
- DRAIN:
  - Keep the request on the old address until ack. The acked word is discarded and branch_predict stays 0.
  - Then go to FETCH at PC.
  - A further redirect during DRAIN overwrites PC, so the latest target wins.
- Stall never blocks a redirect. The IF/DOF register holds only when no redirect is present.
- Throughput: 1 instruction per cycle with a zero-wait memory. Fetch-to-IR latency is 1 edge after ack.

Test Plan:
- Zero-wait ROM with imem_ack tied 1, START_PC 8'h10, 4 edges -> imem_addr 10,11,12,13; PC_1 11,12,13,14; branch_predict 0 then 1,1,1.
- imem_ack asserted every third cycle -> branch_predict 0,0,1 repeating; PC advances once per ack; imem_addr stable while waiting.
- stall high for 3 edges coincident with an ack of word 32'hDEADBEEF at address 8'h05 -> IR/PC_1 frozen, imem_req 0; after release IR = DEADBEEF, PC_1 = 06, then fetch continues at 06.
- redirect_valid with redirect_pc 8'h40 while a request is outstanding with no ack -> branch_predict 0; old address held until ack; that word is dropped; next imem_addr 40; redirect with stall also high -> redirect wins.
- PC at 8'hFF with ack -> PC_1 = 00, next imem_addr 00.
- reset asserted mid-HOLD and mid-DRAIN -> outputs immediately reset, PC 8'h00 (START_PC default), a late ack is ignored, fetch restarts at START_PC.
